// File: rtl/me_result_writer_if.sv
// Result-writer bus: record input stream from the ME core, tagged word stream
// out to the dump/compare logic, plus frame status.
interface me_result_writer_if #(
  parameter int MV_W   = 6,
  parameter int SAD_W  = 16,
  parameter int ADDR_W = 22
);
  logic              mv_valid;
  logic              in_ready;
  logic [MV_W-1:0]   mv_x;
  logic [MV_W-1:0]   mv_y;
  logic [SAD_W-1:0]  sad;
  logic              frame_done;
  logic              out_valid;
  logic              out_ready;
  logic [33:0]       out_data;
  logic [ADDR_W-1:0] out_addr;
  logic [15:0]       frame_cnt;
  logic              err;

  // Environment side: produces records, consumes output words.
  modport master (
    output mv_valid, mv_x, mv_y, sad, frame_done, out_ready,
    input  in_ready, out_valid, out_data, out_addr, frame_cnt, err
  );

  // Writer side.
  modport slave (
    input  mv_valid, mv_x, mv_y, sad, frame_done, out_ready,
    output in_ready, out_valid, out_data, out_addr, frame_cnt, err
  );
endinterface

// File: rtl/me_result_writer.sv
// ME result writer: buffers MV/SAD records in a FIFO and emits them as tagged
// 34-bit words with sequential addresses, closing each frame with a trailer
// word that carries the frame's record count.
module me_result_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int MV_W       = 6,
  parameter int SAD_W      = 16,
  parameter int ADDR_W     = 22
) (
  input  logic               clk,
  input  logic               rst_n,
  me_result_writer_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_TRAIL = 1'b1} state_e;

  // Record payload: sad in the low bits, mv_y above it, mv_x above that.
  function automatic logic [31:0] pack_record(input logic [MV_W-1:0] x,
                                              input logic [MV_W-1:0] y,
                                              input logic [SAD_W-1:0] s);
    logic [31:0] w;
    w = 32'(s) | (32'(y) << SAD_W) | (32'(x) << (SAD_W + MV_W));
    return w;
  endfunction

  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rec_cnt_q, rec_cnt_d;
  logic [ADDR_W-1:0] trailer_val_q, trailer_val_d;
  logic              pend_q, pend_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [33:0]       out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              err_q, err_d;

  logic accept_s, out_fire_s, load_en_s, fifo_empty_s, pop_s, pend_clr_s;

  assign accept_s     = bus.mv_valid && in_ready_q;
  assign out_fire_s   = out_valid_q && bus.out_ready;
  assign load_en_s    = !out_valid_q || bus.out_ready;
  assign fifo_empty_s = (cnt_q == {CNT_W{1'b0}});

  // Output FSM: refill the output register from the FIFO; once the FIFO is
  // drained and a frame is closed, present the trailer and hold it until taken.
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    pend_clr_s  = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (load_en_s) begin
          if (!fifo_empty_s) begin
            pop_s       = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = {2'b01, mem_q[rd_ptr_q]};
          end else if (pend_q) begin
            state_d     = ST_TRAIL;
            out_valid_d = 1'b1;
            out_data_d  = {2'b10, 32'(trailer_val_q)};
          end else begin
            out_valid_d = 1'b0;
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      ST_TRAIL: begin
        if (out_fire_s) begin
          state_d     = ST_RUN;
          out_valid_d = 1'b0;
          pend_clr_s  = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          state_d = ST_TRAIL;
        end
      end
      default: begin
        state_d     = ST_RUN;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Frame bookkeeping, FIFO occupancy and the next-cycle input ready.
  always_comb begin
    rec_cnt_d     = rec_cnt_q + ADDR_W'(accept_s);
    trailer_val_d = trailer_val_q;
    err_d         = err_q;
    if (pend_clr_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (bus.frame_done) begin
      if (!pend_q) begin
        // A record accepted alongside frame_done closes this frame.
        trailer_val_d = rec_cnt_q + ADDR_W'(accept_s);
        rec_cnt_d     = {ADDR_W{1'b0}};
        pend_d        = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = err_q;
    end
    cnt_d      = cnt_q + CNT_W'(accept_s) - CNT_W'(pop_s);
    in_ready_d = (cnt_d != CNT_W'(FIFO_DEPTH)) && !pend_d;
    out_addr_d = out_addr_q + ADDR_W'(out_fire_s);
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      state_q       <= ST_RUN;
      rec_cnt_q     <= {ADDR_W{1'b0}};
      trailer_val_q <= {ADDR_W{1'b0}};
      pend_q        <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 34'd0;
      out_addr_q    <= {ADDR_W{1'b0}};
      frame_cnt_q   <= 16'd0;
      err_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_q + PTR_W'(accept_s);
      rd_ptr_q      <= rd_ptr_q + PTR_W'(pop_s);
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      rec_cnt_q     <= rec_cnt_d;
      trailer_val_q <= trailer_val_d;
      pend_q        <= pend_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_addr_q    <= out_addr_d;
      frame_cnt_q   <= frame_cnt_d;
      err_q         <= err_d;
    end
  end

  // FIFO storage; a reset only rewinds the pointers, stale entries are never read.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_ptr_q] <= pack_record(bus.mv_x, bus.mv_y, bus.sad);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_me_result_writer.sv
// Bench for me_result_writer: directed scenarios plus a randomized phase,
// checked by a scoreboard fed from the input handshakes.
module tb_me_result_writer;
  localparam int MV_W   = 6;
  localparam int SAD_W  = 16;
  localparam int ADDR_W = 22;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  me_result_writer_if #(.MV_W(MV_W), .SAD_W(SAD_W), .ADDR_W(ADDR_W)) bus ();

  me_result_writer #(.FIFO_DEPTH(DEPTH), .MV_W(MV_W), .SAD_W(SAD_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard state: expected words in sink order plus the frame model.
  logic [33:0]       exp_q[$];
  logic [55:0]       seen[$];  // {addr, data} of every word the sink took
  bit                model_pend = 1'b0;
  logic [ADDR_W-1:0] model_rec = '0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [15:0]       model_frames = 16'd0;
  bit                model_err = 1'b0;
  bit                have_stall = 1'b0;
  logic [33:0]       stall_data = 34'd0;

  function automatic logic [33:0] rec_word(logic [5:0] x, logic [5:0] y, logic [15:0] s);
    return {2'b01, 4'b0000, x, y, s};
  endfunction

  function automatic logic [33:0] trl_word(logic [21:0] n);
    return {2'b10, 10'd0, n};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, so it sees what each coming edge will accept.
  always @(negedge clk) begin
    bit acc;
    logic [33:0] w;
    if (!rst_n) begin
      exp_q.delete();
      model_pend   = 1'b0;
      model_rec    = '0;
      exp_addr     = '0;
      model_frames = 16'd0;
      model_err    = 1'b0;
      have_stall   = 1'b0;
    end else begin
      if (have_stall) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_data", 64'(bus.out_data), 64'(stall_data));
      end
      if (model_pend) check("in_ready_while_pend", 64'(bus.in_ready), 64'd0);
      acc = bus.mv_valid && bus.in_ready;
      if (acc) exp_q.push_back(rec_word(bus.mv_x, bus.mv_y, bus.sad));
      if (bus.frame_done && !model_pend) begin
        exp_q.push_back(trl_word(model_rec + ADDR_W'(acc)));
        model_rec  = '0;
        model_pend = 1'b1;
      end else begin
        if (bus.frame_done) model_err = 1'b1;
        model_rec = model_rec + ADDR_W'(acc);
      end
      if (bus.out_valid && bus.out_ready) begin
        seen.push_back({bus.out_addr, bus.out_data});
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
        end else begin
          w = exp_q.pop_front();
          check("out_data", 64'(bus.out_data), 64'(w));
          check("out_addr", 64'(bus.out_addr), 64'(exp_addr));
          if (w[33:32] == 2'b10) begin
            model_pend   = 1'b0;
            model_frames = model_frames + 16'd1;
          end
        end
        exp_addr = exp_addr + 22'd1;
      end
      have_stall = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rec(logic [5:0] x, logic [5:0] y, logic [15:0] s, bit fd);
    bit ok;
    ok = 1'b0;
    bus.mv_x = x; bus.mv_y = y; bus.sad = s;
    bus.mv_valid = 1'b1;
    bus.frame_done = fd;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
      step();
      bus.frame_done = 1'b0;
      if (ok) break;
    end
    bus.mv_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic pulse_fd();
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus.out_ready = 1'b1;
    bus.mv_valid = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n_acc;
    bit acc;
    bus.mv_valid = 1'b0; bus.mv_x = '0; bus.mv_y = '0; bus.sad = '0;
    bus.frame_done = 1'b0; bus.out_ready = 1'b1;

    // 1: reset held for three cycles, then released.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_addr", 64'(bus.out_addr), 64'd0);
    end
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    check("post_rst_err", 64'(bus.err), 64'd0);
    step();

    // 2: three records, frame closed with the third.
    base = seen.size();
    send_rec(6'h3F, 6'h02, 16'h0100, 1'b0);
    send_rec(6'h03, 6'h3C, 16'h1234, 1'b0);
    send_rec(6'h1F, 6'h20, 16'hFFFF, 1'b1);
    drain();
    check("t2_words", 64'(seen.size() - base), 64'd4);
    if (seen.size() - base >= 4) begin
      check("t2_first", 64'(seen[base]), 64'({22'd0, 34'h1_0FC2_0100}));
      check("t2_trailer", 64'(seen[base+3]), 64'({22'd3, 34'h2_0000_0003}));
    end
    check("t2_frame_cnt", 64'(bus.frame_cnt), 64'd1);

    // 3: sink stalled; one record sits in the output register, DEPTH in the FIFO.
    bus.out_ready = 1'b0;
    n_acc = 0;
    bus.mv_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      bus.mv_x = 6'($urandom); bus.mv_y = 6'($urandom); bus.sad = 16'($urandom);
      @(negedge clk);
      if (!bus.in_ready) break;
      n_acc++;
      step();
    end
    step();
    bus.mv_valid = 1'b0;
    check("t3_accepted", 64'(n_acc), 64'(DEPTH + 1));
    repeat (3) step();
    @(negedge clk);
    check("t3_full_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    drain();
    @(negedge clk);
    check("t3_in_ready_back", 64'(bus.in_ready), 64'd1);
    step();
    pulse_fd();
    drain();

    // 4: empty frame, then a second frame_done while its trailer is stalled.
    base = seen.size();
    bus.out_ready = 1'b0;
    pulse_fd();
    repeat (2) step();
    pulse_fd();
    @(negedge clk);
    check("t4_err", 64'(bus.err), 64'd1);
    step();
    drain();
    check("t4_words", 64'(seen.size() - base), 64'd1);
    if (seen.size() > base) check("t4_trailer", 64'(seen[base][33:0]), 64'(34'h2_0000_0000));

    // 5: record offered while a trailer is pending goes into the next frame.
    base = seen.size();
    bus.out_ready = 1'b0;
    pulse_fd();
    bus.mv_x = 6'h05; bus.mv_y = 6'h3B; bus.sad = 16'h00AA;
    bus.mv_valid = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("t5_blocked", 64'(bus.in_ready), 64'd0);
    step();
    bus.out_ready = 1'b1;
    send_rec(6'h05, 6'h3B, 16'h00AA, 1'b0);
    pulse_fd();
    drain();
    check("t5_words", 64'(seen.size() - base), 64'd3);
    if (seen.size() - base >= 3) begin
      check("t5_trailer0", 64'(seen[base][33:0]), 64'(34'h2_0000_0000));
      check("t5_trailer1", 64'(seen[base+2][33:0]), 64'(34'h2_0000_0001));
    end

    // Randomized traffic with backpressure and random frame boundaries.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = bus.mv_valid && bus.in_ready;
      step();
      bus.frame_done = ($urandom_range(0, 29) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.mv_valid || acc) begin
        bus.mv_valid = ($urandom_range(0, 2) != 0);
        bus.mv_x = 6'($urandom); bus.mv_y = 6'($urandom); bus.sad = 16'($urandom);
      end
    end
    step();
    bus.frame_done = 1'b0;
    bus.mv_valid = 1'b0;
    drain();
    pulse_fd();
    drain();
    check("rand_frame_cnt", 64'(bus.frame_cnt), 64'(model_frames));
    check("rand_err", 64'(bus.err), 64'(model_err));

    // 6: reset with five words buffered drops them all.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_rec(6'(i), 6'(i + 1), 16'(i * 7), 1'b0);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("t6_out_valid", 64'(bus.out_valid), 64'd0);
    check("t6_out_addr", 64'(bus.out_addr), 64'd0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_no_word", 64'(bus.out_valid), 64'd0);
    end
    check("t6_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    check("t6_err", 64'(bus.err), 64'd0);
    check("t6_in_ready", 64'(bus.in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
